// File: rtl/a_rx_frame_rs232_pkg.sv
// Shared constants and FSM encoding for the RS232 frame receiver.
package a_rx_frame_rs232_pkg;

  // Receiver FSM state, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  // 100 MHz reference clock / 115200 baud.
  localparam int CLK_PER_BIT_DEFAULT = 868;

  // Character width in bits.
  localparam int DATA_W = 8;

endpackage

// File: rtl/a_rx_frame_rs232_sync2.sv
// Two-flop synchronizer for the asynchronous serial line.
module a_sync2_rs232 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; both reset to the line's idle level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/a_rx_frame_rs232.sv
// RS232 character receiver: start/8 data (LSB first)/stop, with abort
// from an external watchdog. All outputs are registered.
//
// Pulse outputs (rx_done, data_valid, frame_err, abort) are single-cycle
// strobes with no back-pressure: the consumer must take them in the cycle
// they are high. data is qualified by data_valid and held until the next
// good character.
module a_rx_frame_rs232
  import a_rx_frame_rs232_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_DEFAULT
) (
  input  logic              clk_ref,
  input  logic              rst_n,
  input  logic              rx,
  input  logic              timeout_err,
  output logic              rx_busy,
  output logic              rx_done,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              frame_err,
  output logic              abort,
  output state_e            dbg_state_o
);

  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              dv_q, dv_d;
  logic              fe_q, fe_d;
  logic              ab_q, ab_d;
  logic              rx_s;
  logic              rx_prev_q;
  logic              rx_fall;

  a_sync2_rs232 #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk_i  (clk_ref),
    .rst_ni (rst_n),
    .d_i    (rx),
    .q_o    (rx_s)
  );

  // Previous synchronized level, for falling-edge detection.
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) rx_prev_q <= 1'b1;
    else        rx_prev_q <= rx_s;
  end

  assign rx_fall = rx_prev_q & ~rx_s;

  // Next-state, counters, shift register and output strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    ab_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_fall) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          idx_d = '0;
          // Line back high at mid start bit: treat as a glitch.
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_W-1:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == IDX_LAST) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (rx_s) begin
            dv_d   = 1'b1;
            data_d = shift_q;
          end else begin
            fe_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Watchdog abort overrides everything, including a coincident stop sample.
    if (timeout_err && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      data_d  = data_q;
      done_d  = 1'b0;
      dv_d    = 1'b0;
      fe_d    = 1'b0;
      ab_d    = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
      ab_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
      ab_q    <= ab_d;
    end
  end

  assign rx_busy     = busy_q;
  assign rx_done     = done_q;
  assign data        = data_q;
  assign data_valid  = dv_q;
  assign frame_err   = fe_q;
  assign abort       = ab_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/a_rx_frame_rs232.md
A_RX_FRAME_RS232 -- requirements
Module: a_rx_frame_rs232

Interface
REQ-001 SHALL have parameter: CLK_PER_BIT, default 868, clk_ref cycles per RS232 bit (100 MHz / 115200 baud); legal range 4..2^20.
REQ-002 SHALL have port: clk_ref  input  1  reference clock; all logic on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 SHALL have port: rx  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port: timeout_err  input  1  watchdog error from the downstream timeout stage; aborts the frame in progress.
REQ-006 SHALL have port: rx_busy  output  1  high while a character is being received; drives the timeout stage start input.
REQ-007 SHALL have port: rx_done  output  1  one-cycle pulse at end of character (good or bad); drives the timeout stage fin_timeout input.
REQ-008 SHALL have port: data  output  8  last received byte, held until the next good byte.
REQ-009 SHALL have port: data_valid  output  1  one-cycle pulse, data is new.
REQ-010 SHALL have port: frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-011 SHALL have port: abort  output  1  one-cycle pulse, frame dropped due to timeout_err.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer; rx_s is the synchronized line; falling edge = rx_s low while its previous value was high.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP; one bit counter of width clog2(CLK_PER_BIT); 3-bit index counter.
REQ-014 IDLE: on falling edge of rx_s -> START, bit counter loaded to 0, rx_busy high from the next cycle.
REQ-015 START: sample rx_s when bit counter reaches CLK_PER_BIT/2 - 1 (integer division); low -> DATA, counter cleared; high -> IDLE (glitch rejected, no pulse outputs).
REQ-016 DATA: sample rx_s every CLK_PER_BIT cycles; shift in LSB first; after 8th sample -> STOP.
REQ-017 STOP: sample rx_s after a further CLK_PER_BIT cycles; high -> data updated and data_valid pulsed next cycle; low -> frame_err pulsed next cycle, data unchanged; both cases pulse rx_done in the same cycle and return to IDLE.
REQ-018 rx_busy SHALL be high in START, DATA, STOP and low in IDLE.
REQ-019 Re-arming: a falling edge arriving in the first IDLE cycle after STOP SHALL be accepted (back-to-back characters, no idle bit required beyond the stop bit).
REQ-020 timeout_err high in START/DATA/STOP SHALL force IDLE the next cycle, pulse abort, suppress data_valid/frame_err/rx_done; timeout_err in IDLE is ignored.
REQ-021 Simultaneous STOP sample and timeout_err: abort wins; no data_valid.
REQ-022 data_valid and frame_err SHALL never be high in the same cycle; at most one of data_valid/frame_err/abort per character.
REQ-023 Break condition (rx held low): frame_err once, then no new character until rx_s returns high and falls again.

Reset
REQ-024 On rst_n low: FSM IDLE; counters 0; synchronizer flops 1; data 8'h00; rx_busy, rx_done, data_valid, frame_err, abort all 0.
REQ-025 Reset asserted mid-frame SHALL discard the partial byte; no pulse outputs on release.
REQ-026 Deassertion is synchronized externally; block takes no reset-release action.

Structure
REQ-027 Shared package SHALL hold the FSM state encoding (2-bit), the default CLK_PER_BIT and the data width constant 8.
REQ-028 The 2-flop synchronizer SHALL be a sub-module a_sync2_rs232 (parameter reset value 1).
REQ-029 Implementation 120-400 lines; no latches; all outputs registered.

Verification (CLK_PER_BIT=16 in all benches)
REQ-030 Send 0xA5 (start, 8 data LSB first, stop) -> exactly one data_valid with data=0xA5, one rx_done, frame_err=0, abort=0.
REQ-031 Low glitch of 4 cycles on idle rx -> rx_busy pulses then drops at half-bit sample; no data_valid, frame_err, rx_done.
REQ-032 Send 0x3C with stop bit low -> frame_err and rx_done pulse once, data keeps previous value, data_valid=0.
REQ-033 Assert timeout_err during data bit 4 -> abort pulse, rx_busy low next cycle, no data_valid; next byte 0x55 received correctly.
REQ-034 Back-to-back 0x00 then 0xFF with single stop bit -> two data_valid pulses, values 0x00 then 0xFF.
REQ-035 rst_n low during data bit 2 of 0x81, then release -> all outputs 0, data=0x00; subsequent 0x81 received correctly.
